// File: rtl/seq_mul24_frac_pkg.sv
// Shared definitions for the sequential mantissa multiplier.
//   MANT_W      mantissa width including the integer bit (1.23 format)
//   PROD_W      raw product width (2.46 format)
//   CNT_W       width of the iteration counter
//   mul_state_t multiplier control states
package seq_mul24_frac_pkg;

    localparam int MANT_W = 24;
    localparam int PROD_W = 2 * MANT_W;
    localparam int CNT_W  = $clog2(MANT_W);

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_RUN,
        MUL_DONE
    } mul_state_t;

endpackage

// File: rtl/seq_mul24_frac_if.sv
// Handshake and result bundle of the mantissa multiplier.
//   start/a/b                          request side, driven by the caller
//   busy/done                          status, driven by the multiplier
//   product/mant/norm_shift/guard/sticky  results, valid from the done pulse
//                                      and held until the next completion
// Modports: master = caller, slave = multiplier.
interface seq_mul24_frac_if;
    import seq_mul24_frac_pkg::*;

    logic              start;
    logic [MANT_W-1:0] a;
    logic [MANT_W-1:0] b;
    logic              busy;
    logic              done;
    logic [PROD_W-1:0] product;
    logic [MANT_W-1:0] mant;
    logic              norm_shift;
    logic              guard;
    logic              sticky;

    modport master (
        output start, a, b,
        input  busy, done, product, mant, norm_shift, guard, sticky
    );

    modport slave (
        input  start, a, b,
        output busy, done, product, mant, norm_shift, guard, sticky
    );

endinterface

// File: rtl/seq_mul24_frac_norm.sv
// Combinational normalizer for a 2.46 mantissa product.
//   product_i     raw product
//   mant_o        1.23 mantissa taken from the top of the product
//   norm_shift_o  1 when product >= 2.0 (exponent must be incremented)
//   guard_o       first bit below the mantissa LSB
//   sticky_o      OR of all bits below the guard bit
module mant_mul_norm
    import seq_mul24_frac_pkg::*;
(
    input  logic [PROD_W-1:0] product_i,
    output logic [MANT_W-1:0] mant_o,
    output logic              norm_shift_o,
    output logic              guard_o,
    output logic              sticky_o
);

    always_comb begin
        mant_o       = product_i[PROD_W-2 -: MANT_W];
        norm_shift_o = 1'b0;
        guard_o      = product_i[MANT_W-2];
        sticky_o     = |product_i[MANT_W-3:0];
        // Product in [2.0, 4.0): take the window one bit higher.
        if (product_i[PROD_W-1]) begin
            mant_o       = product_i[PROD_W-1 -: MANT_W];
            norm_shift_o = 1'b1;
            guard_o      = product_i[MANT_W-1];
            sticky_o     = |product_i[MANT_W-2:0];
        end
    end

endmodule

// File: rtl/seq_mul24_frac.sv
// Radix-2 shift-add mantissa multiplier, one multiplier bit per clock.
// Produces the full 2.46 product of two 1.23 mantissas plus the
// normalized 1.23 mantissa with guard/sticky for the rounding stage.
//   clk     clock, all state on the rising edge
//   rst     synchronous active-high reset, aborts any operation
//   mul_if  slave side of the start/busy/done handshake and results
module seq_mul24_frac
    import seq_mul24_frac_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    seq_mul24_frac_if.slave         mul_if
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MANT_W - 1);

    mul_state_t        state_q, state_d;
    logic [MANT_W:0]   acc_q, acc_d;
    logic [MANT_W-1:0] mlr_q, mlr_d;
    logic [MANT_W-1:0] mcand_q, mcand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [MANT_W:0]   sum;
    logic              load_res;

    logic [PROD_W-1:0] product_q;
    logic [MANT_W-1:0] mant_q;
    logic              norm_shift_q, guard_q, sticky_q;

    logic [MANT_W-1:0] mant_n;
    logic              norm_shift_n, guard_n, sticky_n;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mlr_d    = mlr_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
        sum      = '0;
        load_res = 1'b0;
        case (state_q)
            MUL_IDLE, MUL_DONE: begin
                if (mul_if.start) begin
                    state_d = MUL_RUN;
                    mcand_d = mul_if.a;
                    mlr_d   = mul_if.b;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = MUL_IDLE;
                end
            end
            MUL_RUN: begin
                // acc never exceeds MANT_W bits after a shift, so the
                // MANT_W+1 bit sum cannot overflow.
                sum            = acc_q + (mlr_q[0] ? {1'b0, mcand_q} : '0);
                {acc_d, mlr_d} = {sum, mlr_q} >> 1;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = MUL_DONE;
                    load_res = 1'b1;
                end
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    // The normalizer looks at the product being formed by the last step,
    // so results land in the same edge that enters DONE.
    mant_mul_norm u_norm (
        .product_i    ({acc_d[MANT_W-1:0], mlr_d}),
        .mant_o       (mant_n),
        .norm_shift_o (norm_shift_n),
        .guard_o      (guard_n),
        .sticky_o     (sticky_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= MUL_IDLE;
            product_q    <= '0;
            mant_q       <= '0;
            norm_shift_q <= 1'b0;
            guard_q      <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_res) begin
                product_q    <= {acc_d[MANT_W-1:0], mlr_d};
                mant_q       <= mant_n;
                norm_shift_q <= norm_shift_n;
                guard_q      <= guard_n;
                sticky_q     <= sticky_n;
            end
        end
    end

    // Working registers are always reloaded on accept, so they need no reset.
    always_ff @(posedge clk) begin
        acc_q   <= acc_d;
        mlr_q   <= mlr_d;
        mcand_q <= mcand_d;
        cnt_q   <= cnt_d;
    end

    assign mul_if.busy       = (state_q == MUL_RUN);
    assign mul_if.done       = (state_q == MUL_DONE);
    assign mul_if.product    = product_q;
    assign mul_if.mant       = mant_q;
    assign mul_if.norm_shift = norm_shift_q;
    assign mul_if.guard      = guard_q;
    assign mul_if.sticky     = sticky_q;

endmodule
